// File: rtl/dout_writer.sv
// Serial frame writer: latches eight 24-bit channel samples and shifts them
// out MSB first on four data lines, framed by drdy_o and clocked by dclk_o.
// A frame is one drdy period followed by 48 data periods, then an idle gap.
module dout_writer #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic        continuous_i,
  input  logic [23:0] ch1_i,
  input  logic [23:0] ch2_i,
  input  logic [23:0] ch3_i,
  input  logic [23:0] ch4_i,
  input  logic [23:0] ch5_i,
  input  logic [23:0] ch6_i,
  input  logic [23:0] ch7_i,
  input  logic [23:0] ch8_i,
  output logic        drdy_o,
  output logic        dclk_o,
  output logic        dout0_o,
  output logic        dout1_o,
  output logic        dout2_o,
  output logic        dout3_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o,
  output logic [31:0] frame_count_o
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_HIGH = CW'(CLK_DIV);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [5:0]    PER_LAST = 6'd48;

  typedef enum logic [1:0] {IDLE, DRDY, SHIFT, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cyc_reg, cyc_next;      // clk_i cycle within a dclk period
  logic [5:0]       per_reg, per_next;      // dclk period index, 0 = drdy period
  logic [GW-1:0]    gap_reg, gap_next;
  logic [3:0][47:0] sh_reg, sh_next;        // one 48-bit word per data line
  logic [3:0][47:0] chan_words;

  logic             drdy_reg, dclk_reg, busy_reg, done_reg, overrun_reg;
  logic [3:0]       dout_reg;
  logic [31:0]      frame_count_reg;

  logic             period_end, latch, active_next;

  assign chan_words[0] = {ch1_i, ch2_i};
  assign chan_words[1] = {ch3_i, ch4_i};
  assign chan_words[2] = {ch5_i, ch6_i};
  assign chan_words[3] = {ch7_i, ch8_i};

  // Next-state, counter and shift-register computation.
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    per_next   = per_reg;
    gap_next   = gap_reg;
    sh_next    = sh_reg;
    latch      = 1'b0;
    period_end = (cyc_reg == CYC_LAST);

    case (state_reg)
      IDLE: begin
        if (start_i) latch = 1'b1;
      end
      DRDY: begin
        cyc_next = period_end ? '0 : cyc_reg + 1'b1;
        if (period_end) begin
          state_next = SHIFT;
          per_next   = 6'd1;
        end
      end
      SHIFT: begin
        cyc_next = period_end ? '0 : cyc_reg + 1'b1;
        if (period_end) begin
          if (per_reg == PER_LAST) begin
            // Frame data complete: gap, back-to-back restart, or idle.
            if (GAP_CYCLES > 0) begin
              state_next = GAP;
              gap_next   = '0;
            end else if (continuous_i) begin
              latch = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            // Period 1 repeats bit 47 from the drdy period; shift from period 2 on.
            per_next = per_reg + 6'd1;
            for (int i = 0; i < 4; i++) sh_next[i] = {sh_reg[i][46:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) begin
          if (continuous_i) latch = 1'b1;
          else              state_next = IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (latch) begin
      state_next = DRDY;
      sh_next    = chan_words;
      cyc_next   = '0;
      per_next   = '0;
    end

    active_next = (state_next == DRDY) || (state_next == SHIFT);
  end

  // State, counters and shift registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      per_reg   <= '0;
      gap_reg   <= '0;
      sh_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      per_reg   <= per_next;
      gap_reg   <= gap_next;
      sh_reg    <= sh_next;
    end
  end

  // Registered outputs derived from the upcoming state so they align with it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drdy_reg        <= 1'b0;
      dclk_reg        <= 1'b0;
      dout_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      drdy_reg <= (state_next == DRDY);
      dclk_reg <= active_next && (cyc_next >= CYC_HIGH);
      for (int i = 0; i < 4; i++) dout_reg[i] <= active_next & sh_next[i][47];
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == SHIFT) && (per_next == PER_LAST) && (cyc_next == CYC_LAST);
      if (start_i && (state_reg != IDLE)) overrun_reg <= 1'b1;
      if (done_reg) frame_count_reg <= frame_count_reg + 32'd1;
    end
  end

  assign drdy_o        = drdy_reg;
  assign dclk_o        = dclk_reg;
  assign dout0_o       = dout_reg[0];
  assign dout1_o       = dout_reg[1];
  assign dout2_o       = dout_reg[2];
  assign dout3_o       = dout_reg[3];
  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign overrun_o     = overrun_reg;
  assign frame_count_o = frame_count_reg;

endmodule

// File: tb/tb_dout_writer.sv
// Bench for dout_writer: table of channel sets with hand-computed line words,
// plus sequences for overrun, continuous mode, mid-frame reset, count wrap
// and a zero-gap instance.
module tb_dout_writer;

  logic             clk;
  logic             reset_ni;
  logic             start, cont;
  logic             start_g0, cont_g0;
  logic [7:0][23:0] ch;

  logic             drdy, dclk, busy, done, overrun;
  logic [3:0]       dout;
  logic [31:0]      frame_count;
  logic             drdy_g0, dclk_g0, busy_g0, done_g0, overrun_g0;
  logic [3:0]       dout_g0;
  logic [31:0]      frame_count_g0;

  int n_cmp = 0;
  int n_bad = 0;

  dout_writer #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start), .continuous_i(cont),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .drdy_o(drdy), .dclk_o(dclk),
    .dout0_o(dout[0]), .dout1_o(dout[1]), .dout2_o(dout[2]), .dout3_o(dout[3]),
    .busy_o(busy), .done_o(done), .overrun_o(overrun), .frame_count_o(frame_count)
  );

  dout_writer #(.CLK_DIV(2), .GAP_CYCLES(0)) dut_g0 (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_g0), .continuous_i(cont_g0),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .drdy_o(drdy_g0), .dclk_o(dclk_g0),
    .dout0_o(dout_g0[0]), .dout1_o(dout_g0[1]), .dout2_o(dout_g0[2]), .dout3_o(dout_g0[3]),
    .busy_o(busy_g0), .done_o(done_g0), .overrun_o(overrun_g0), .frame_count_o(frame_count_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: samples the four lines on each dclk rising edge.
  logic [3:0][47:0] rx_sh;
  int               rx_cnt = 0;
  always @(posedge dclk) begin
    if (drdy) begin
      rx_cnt <= 0;
    end else if (rx_cnt < 48) begin
      for (int i = 0; i < 4; i++) rx_sh[i] <= {rx_sh[i][46:0], dout[i]};
      rx_cnt <= rx_cnt + 1;
    end
  end

  typedef struct packed {
    logic [7:0][23:0] ch;
    logic [3:0][47:0] line;
  } vec_t;

  vec_t        vecs [3];
  logic [31:0] exp_fc;

  function automatic vec_t mk(input logic [23:0] c1, c2, c3, c4, c5, c6, c7, c8,
                              input logic [47:0] l0, l1, l2, l3);
    vec_t v;
    v.ch[0] = c1; v.ch[1] = c2; v.ch[2] = c3; v.ch[3] = c4;
    v.ch[4] = c5; v.ch[5] = c6; v.ch[6] = c7; v.ch[7] = c8;
    v.line[0] = l0; v.line[1] = l1; v.line[2] = l2; v.line[3] = l3;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One frame from a table entry; caller is positioned at a falling edge.
  task automatic run_frame(input int vi, input bit inject);
    int          first_drdy, n_drdy, n_done, done_k, gap_bad;
    logic [31:0] fc_at_done, fc_after;
    logic [3:0][47:0] rx_got;
    int          rx_n;
    first_drdy = -1; n_drdy = 0; n_done = 0; done_k = -1; gap_bad = 0;
    fc_at_done = '0; fc_after = '0; rx_got = '0; rx_n = 0;
    ch    = vecs[vi].ch;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 202; k++) begin
      if (k == 20) ch = ~vecs[vi].ch;
      if (inject && k == 50) start = 1'b1;
      if (inject && k == 51) start = 1'b0;
      if (drdy) begin
        n_drdy++;
        if (first_drdy < 0) first_drdy = k;
      end
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (k == 196) fc_at_done = frame_count;
      if (k == 197) begin
        fc_after = frame_count;
        rx_got   = rx_sh;
        rx_n     = rx_cnt;
      end
      if (k >= 197 && k <= 200 && (dclk || dout != 4'd0 || !busy)) gap_bad++;
      @(negedge clk);
    end
    check($sformatf("v%0d first_drdy_cycle", vi), 64'(first_drdy), 64'd1);
    check($sformatf("v%0d drdy_cycles", vi), 64'(n_drdy), 64'd4);
    check($sformatf("v%0d done_count", vi), 64'(n_done), 64'd1);
    check($sformatf("v%0d done_cycle", vi), 64'(done_k), 64'd196);
    check($sformatf("v%0d count_at_done", vi), 64'(fc_at_done), 64'(exp_fc));
    exp_fc = exp_fc + 32'd1;
    check($sformatf("v%0d count_after", vi), 64'(fc_after), 64'(exp_fc));
    check($sformatf("v%0d gap_quiet", vi), 64'(gap_bad), 64'd0);
    check($sformatf("v%0d rx_bits", vi), 64'(rx_n), 64'd48);
    for (int i = 0; i < 4; i++)
      check($sformatf("v%0d line%0d", vi, i), 64'(rx_got[i]), 64'(vecs[vi].line[i]));
    check($sformatf("v%0d idle_after", vi), 64'(busy), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          rise [3];
    int          nr, nd, dclk_bad, g0_done_k;
    logic [23:0] got [3];
    logic [31:0] fc_base;
    logic        prev;
    logic        exp_dclk;

    vecs[0] = mk(24'h800001, 24'h7FFFFF, 24'h123456, 24'h123456,
                 24'h123456, 24'h123456, 24'h123456, 24'h123456,
                 48'h8000017FFFFF, 48'h123456123456, 48'h123456123456, 48'h123456123456);
    vecs[1] = mk(24'h000000, 24'hFFFFFF, 24'hA5A5A5, 24'h5A5A5A,
                 24'h000001, 24'h800000, 24'hFFFFFE, 24'h7FFFFE,
                 48'h000000FFFFFF, 48'hA5A5A55A5A5A, 48'h000001800000, 48'hFFFFFE7FFFFE);
    vecs[2] = mk(24'h111111, 24'h222222, 24'h333333, 24'h444444,
                 24'h555555, 24'h666666, 24'h777777, 24'h888888,
                 48'h111111222222, 48'h333333444444, 48'h555555666666, 48'h777777888888);

    reset_ni = 1'b0; start = 1'b0; cont = 1'b0; start_g0 = 1'b0; cont_g0 = 1'b0;
    ch = vecs[0].ch;
    exp_fc = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({drdy, dclk, dout, busy, done, overrun}), 64'd0);
    check("reset_count", 64'(frame_count), 64'd0);

    // Release reset and request a frame on the very first edge; overrun injected.
    reset_ni = 1'b1;
    run_frame(0, 1'b1);
    check("overrun_set", 64'(overrun), 64'd1);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Continuous mode: three frames, ch1 incremented at each done.
    fc_base = exp_fc;
    ch = vecs[2].ch;
    ch[0] = 24'd1;
    cont = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nr = 0; nd = 0; prev = 1'b0;
    for (int i = 0; i < 3; i++) begin rise[i] = 0; got[i] = '0; end
    for (int k = 1; k <= 605; k++) begin
      if (drdy && !prev) begin
        if (nr < 3) rise[nr] = k;
        nr++;
      end
      prev = drdy;
      if (done) begin
        if (nd < 3) got[nd] = rx_sh[0][47:24];
        nd++;
        ch[0] = ch[0] + 24'd1;
        if (nd == 3) cont = 1'b0;
      end
      @(negedge clk);
    end
    check("cont_frames", 64'(nr), 64'd3);
    check("cont_spacing1", 64'(rise[1] - rise[0]), 64'd200);
    check("cont_spacing2", 64'(rise[2] - rise[1]), 64'd200);
    for (int i = 0; i < 3; i++)
      check($sformatf("cont_value%0d", i), 64'(got[i]), 64'(i + 1));
    check("cont_count", 64'(frame_count), 64'(fc_base + 32'd3));
    exp_fc = fc_base + 32'd3;
    check("cont_idle", 64'(busy), 64'd0);

    // Reset in the high phase of dclk period 20, between clock edges.
    ch = vecs[1].ch;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k < 83; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("pre_reset_dclk", 64'(dclk), 64'd1);
    #1 reset_ni = 1'b0;
    #1;
    check("async_reset_outputs", 64'({drdy, dclk, dout, busy, done, overrun}), 64'd0);
    check("async_reset_count", 64'(frame_count), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("reset_no_done", 64'(nd), 64'd0);
    exp_fc = '0;
    reset_ni = 1'b1;
    run_frame(2, 1'b0);

    // Count wrap.
    force dut.frame_count_reg = 32'hFFFFFFFF;
    #1 release dut.frame_count_reg;
    @(negedge clk);
    exp_fc = 32'hFFFFFFFF;
    check("forced_count", 64'(frame_count), 64'hFFFFFFFF);
    run_frame(1, 1'b0);
    check("wrapped_count", 64'(frame_count), 64'd0);

    // Zero-gap instance in continuous mode.
    cont_g0 = 1'b1; start_g0 = 1'b1;
    ch = vecs[0].ch;
    @(posedge clk);
    @(negedge clk);
    start_g0 = 1'b0;
    nr = 0; dclk_bad = 0; g0_done_k = -1; prev = 1'b0;
    for (int i = 0; i < 3; i++) rise[i] = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k == 300) cont_g0 = 1'b0;
      exp_dclk = (k <= 392) && (((k - 1) % 4) >= 2);
      if (dclk_g0 !== exp_dclk) dclk_bad++;
      if (drdy_g0 && !prev) begin
        if (nr < 3) rise[nr] = k;
        nr++;
      end
      prev = drdy_g0;
      if (done_g0 && g0_done_k < 0) g0_done_k = k;
      if (k == 196) check("g0_count_at_done", 64'(frame_count_g0), 64'd0);
      if (k == 197) begin
        check("g0_count_after", 64'(frame_count_g0), 64'd1);
        check("g0_drdy_restart", 64'(drdy_g0), 64'd1);
      end
      @(negedge clk);
    end
    check("g0_done_cycle", 64'(g0_done_k), 64'd196);
    check("g0_frames", 64'(nr), 64'd2);
    check("g0_second_drdy", 64'(rise[1]), 64'd197);
    check("g0_dclk_pattern", 64'(dclk_bad), 64'd0);
    check("g0_final_count", 64'(frame_count_g0), 64'd2);
    check("g0_idle", 64'(busy_g0), 64'd0);
    check("g0_no_overrun", 64'(overrun_g0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
